// File: rtl/czonotope_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : czonotope_pkg
//  Description : Shared types and helpers for the constrained-zonotope
//                readout path.
//                - section_e : stream section tags (c, G, A, b)
//                - state_e   : readout FSM states
//                - default dimension limits and the width helpers that
//                  derive address and counter widths from them
//  Revision    : 1.0 - initial release
// ============================================================================
package czonotope_pkg;

  // Default dimension limits and word width
  localparam int CZ_NMAX       = 3;
  localparam int CZ_NGMAX      = 15;
  localparam int CZ_NCMAX      = 12;
  localparam int CZ_DATA_WIDTH = 32;
  localparam int CZ_SEC_W      = 2;

  typedef enum logic [CZ_SEC_W-1:0] {
    SEC_C = 2'd0,
    SEC_G = 2'd1,
    SEC_A = 2'd2,
    SEC_B = 2'd3
  } section_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Address width for a memory of v entries.
  // Never returns 0, so degenerate sizes still give a legal vector.
  function automatic int cz_w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int cz_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/czonotope_readout_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : readout_fifo2
//  Description : 2-entry FIFO for tagged readout words.
//                The payload is {last, section, data}; it can also carry a
//                header flag when the top level widens DW.
//                The head entry is visible on dout_o while count_o != 0.
//                The caller never pushes into a full FIFO unless it pops
//                in the same cycle.
//  Ports       : clk_i, rst_i - clock, synchronous active-high reset
//                push_i/din_i - write strobe and payload
//                pop_i        - consume head (ignored when empty)
//                dout_o       - head payload
//                count_o      - occupancy 0..2
//  Revision    : 1.0 - initial release
// ============================================================================
module readout_fifo2 #(
  parameter int DW = 35
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    count_q;
  logic          pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/czonotope_readout.sv
`default_nettype none
// ============================================================================
//  Module      : czonotope_readout
//  Description : Streams a constrained zonotope (c, G, A, b) out of its four
//                result memories as one ordered valid/ready word stream.
//                The memories have 1-cycle read latency.
//                - Word order: c, G row-major, A row-major, b.
//                - Empty sections are skipped with no bubble.
//                Optional macro CZ_READOUT_HEADER_EN:
//                - prepends a packed-dimension header word;
//                - adds the m_thdr_o output.
//  Ports       : clk_i/rst_i        clock, synchronous active-high reset
//                start_i, n_i/ng_i/nc_i  start pulse and dimensions
//                *_addr_o/*_rdata_i  memory read ports (c, G, A, b)
//                m_t*                output stream (data/section/valid/
//                                    ready/last[/hdr])
//                busy_o/done_o       transfer status
//  Revision    : 1.0 - initial release
// ============================================================================
module czonotope_readout
  import czonotope_pkg::*;
#(
  parameter int NMAX       = CZ_NMAX,
  parameter int NGMAX      = CZ_NGMAX,
  parameter int NCMAX      = CZ_NCMAX,
  parameter int DATA_WIDTH = CZ_DATA_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [$clog2(NMAX+1)-1:0]    n_i,
  input  logic [$clog2(NGMAX+1)-1:0]   ng_i,
  input  logic [$clog2(NCMAX+1)-1:0]   nc_i,
  output logic [cz_w(NMAX)-1:0]        c_addr_o,
  input  logic [DATA_WIDTH-1:0]        c_rdata_i,
  output logic [cz_w(NMAX)-1:0]        G_raddr_o,
  output logic [cz_w(NGMAX)-1:0]       G_caddr_o,
  input  logic [DATA_WIDTH-1:0]        G_rdata_i,
  output logic [cz_w(NCMAX)-1:0]       A_raddr_o,
  output logic [cz_w(NGMAX)-1:0]       A_caddr_o,
  input  logic [DATA_WIDTH-1:0]        A_rdata_i,
  output logic [cz_w(NCMAX)-1:0]       b_addr_o,
  input  logic [DATA_WIDTH-1:0]        b_rdata_i,
  output logic [DATA_WIDTH-1:0]        m_tdata_o,
  output logic [CZ_SEC_W-1:0]          m_tsection_o,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic                         m_tlast_o,
`ifdef CZ_READOUT_HEADER_EN
  output logic                         m_thdr_o,
`endif
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int NDW  = $clog2(NMAX+1);
  localparam int NGDW = $clog2(NGMAX+1);
  localparam int NCDW = $clog2(NCMAX+1);
  localparam int NAW  = cz_w(NMAX);
  localparam int NGAW = cz_w(NGMAX);
  localparam int NCAW = cz_w(NCMAX);
  localparam int RW   = cz_w(cz_max(NMAX, NCMAX));
  localparam int CW   = NGAW;
`ifdef CZ_READOUT_HEADER_EN
  localparam int HFW  = cz_max(NDW, cz_max(NGDW, NCDW));
  localparam int PW   = DATA_WIDTH + CZ_SEC_W + 2;
`else
  localparam int PW   = DATA_WIDTH + CZ_SEC_W + 1;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e          state_q;
  logic [NDW-1:0]  n_q;
  logic [NGDW-1:0] ng_q;
  logic [NCDW-1:0] nc_q;
  logic [3:0]      has_q;      // non-empty sections, indexed by section_e
  section_e        sec_q, sec_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            infl_vld_q;
  section_e        infl_sec_q;
  logic            infl_last_q;
  logic            done_q;
  logic            busy_q;
`ifdef CZ_READOUT_HEADER_EN
  logic            hdr_pend_q;
  logic            infl_hdr_q;
`endif

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic [3:0]      has_in;
  section_e        first_sec;
  logic [RW-1:0]   rows;
  logic [CW-1:0]   cols;
  logic            col_last, row_last;
  logic            nxt_found;
  section_e        nxt_sec;
  logic            hdr_pend;
  logic            empty_run;
  logic [2:0]      occ;
  logic            hs;
  logic            slot_ok;
  logic            issue;
  logic            last_issue;
  logic [1:0]      fifo_cnt;
  logic [PW-1:0]   fifo_dout;
  logic [PW-1:0]   push_word;
  logic [DATA_WIDTH-1:0] push_data;
  logic            drain_done;

`ifdef CZ_READOUT_HEADER_EN
  assign hdr_pend = hdr_pend_q;
`else
  assign hdr_pend = 1'b0;
`endif

  // Section presence from the dims being latched
  assign has_in[0] = (n_i != '0);
  assign has_in[1] = (n_i != '0) && (ng_i != '0);
  assign has_in[2] = (nc_i != '0) && (ng_i != '0);
  assign has_in[3] = (nc_i != '0);

  always_comb begin
    first_sec = SEC_C;
    for (int i = 3; i >= 0; i--) begin
      if (has_in[i]) first_sec = section_e'(i[1:0]);
    end
  end

  // Row/column extents of the current section (c and b are single-column)
  always_comb begin
    rows = RW'(n_q);
    cols = CW'(1);
    case (sec_q)
      SEC_C:   begin rows = RW'(n_q);  cols = CW'(1);    end
      SEC_G:   begin rows = RW'(n_q);  cols = CW'(ng_q); end
      SEC_A:   begin rows = RW'(nc_q); cols = CW'(ng_q); end
      default: begin rows = RW'(nc_q); cols = CW'(1);    end
    endcase
  end

  // Modular compare: an extent equal to 2**width truncates to 0 and still
  // lands on the all-ones last index.
  assign col_last = (col_q == cols - CW'(1));
  assign row_last = (row_q == rows - RW'(1));

  // Next non-empty section after the current one
  always_comb begin
    nxt_found = 1'b0;
    nxt_sec   = sec_q;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(sec_q)) && has_q[i]) begin
        nxt_found = 1'b1;
        nxt_sec   = section_e'(i[1:0]);
      end
    end
  end

  assign empty_run = (has_q == 4'd0) && !hdr_pend;
  assign hs        = m_tvalid_o && m_tready_i;
  assign occ       = {1'b0, fifo_cnt} + {2'b00, infl_vld_q};
  // Occupancy plus in-flight never exceeds the FIFO depth
  assign slot_ok   = (occ < 3'd2) || ((occ == 3'd2) && hs);
  assign issue     = (state_q == READ) && !empty_run && slot_ok;
  assign last_issue = hdr_pend ? (has_q == 4'd0)
                               : (col_last && row_last && !nxt_found);
  assign drain_done = !infl_vld_q &&
                      ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && hs));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    sec_d = sec_q;
    if (issue && !hdr_pend) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d = '0;
          sec_d = nxt_sec;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Addresses follow the counters in READ; unused ports sit at 0
  always_comb begin
    c_addr_o  = '0;
    G_raddr_o = '0;
    G_caddr_o = '0;
    A_raddr_o = '0;
    A_caddr_o = '0;
    b_addr_o  = '0;
    if ((state_q == READ) && !hdr_pend) begin
      case (sec_q)
        SEC_C: c_addr_o = row_q[NAW-1:0];
        SEC_G: begin
          G_raddr_o = row_q[NAW-1:0];
          G_caddr_o = col_q;
        end
        SEC_A: begin
          A_raddr_o = row_q[NCAW-1:0];
          A_caddr_o = col_q;
        end
        default: b_addr_o = row_q[NCAW-1:0];
      endcase
    end
  end

  // Returning read data is selected by the in-flight section tag
  always_comb begin
    case (infl_sec_q)
      SEC_C:   push_data = c_rdata_i;
      SEC_G:   push_data = G_rdata_i;
      SEC_A:   push_data = A_rdata_i;
      default: push_data = b_rdata_i;
    endcase
`ifdef CZ_READOUT_HEADER_EN
    if (infl_hdr_q) begin
      push_data = '0;
      push_data[HFW-1:0]       = HFW'(n_q);
      push_data[2*HFW-1:HFW]   = HFW'(ng_q);
      push_data[3*HFW-1:2*HFW] = HFW'(nc_q);
    end
`endif
  end

`ifdef CZ_READOUT_HEADER_EN
  assign push_word = {infl_hdr_q, infl_last_q, infl_sec_q, push_data};
`else
  assign push_word = {infl_last_q, infl_sec_q, push_data};
`endif

  readout_fifo2 #(
    .DW (PW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (infl_vld_q),
    .din_i   (push_word),
    .pop_i   (m_tready_i),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt)
  );

  assign m_tvalid_o   = (fifo_cnt != 2'd0);
  assign m_tdata_o    = m_tvalid_o ? fifo_dout[DATA_WIDTH-1:0] : '0;
  assign m_tsection_o = m_tvalid_o ? fifo_dout[DATA_WIDTH +: CZ_SEC_W] : '0;
  assign m_tlast_o    = m_tvalid_o && fifo_dout[DATA_WIDTH+CZ_SEC_W];
`ifdef CZ_READOUT_HEADER_EN
  assign m_thdr_o     = m_tvalid_o && fifo_dout[DATA_WIDTH+CZ_SEC_W+1];
`endif
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  // --------------------------------------------------------------------------
  // FSM, counters and in-flight tag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      n_q         <= '0;
      ng_q        <= '0;
      nc_q        <= '0;
      has_q       <= 4'd0;
      sec_q       <= SEC_C;
      row_q       <= '0;
      col_q       <= '0;
      infl_vld_q  <= 1'b0;
      infl_sec_q  <= SEC_C;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CZ_READOUT_HEADER_EN
      hdr_pend_q  <= 1'b0;
      infl_hdr_q  <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      row_q      <= row_d;
      col_q      <= col_d;
      sec_q      <= sec_d;
      infl_vld_q <= issue;
      if (issue) begin
        infl_sec_q  <= sec_q;
        infl_last_q <= last_issue;
`ifdef CZ_READOUT_HEADER_EN
        infl_hdr_q  <= hdr_pend_q;
        hdr_pend_q  <= 1'b0;
`endif
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            n_q     <= n_i;
            ng_q    <= ng_i;
            nc_q    <= nc_i;
            has_q   <= has_in;
            sec_q   <= first_sec;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= READ;
`ifdef CZ_READOUT_HEADER_EN
            hdr_pend_q <= 1'b1;
`endif
          end
        end
        READ: begin
          if (empty_run) begin
            // Nothing to read: finish straight away
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (issue && last_issue) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_czonotope_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_czonotope_readout
//  Description : Self-checking bench for czonotope_readout.
//                - Memories are randomly filled; a reference list of the
//                  expected words is built from the dims with nested loops.
//                - The stream is compared word by word at each handshake.
//                - Timing of first valid and of done is also checked.
//                Honours CZ_READOUT_HEADER_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_czonotope_readout;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  n_i;
  logic [3:0]  ng_i;
  logic [3:0]  nc_i;
  logic [1:0]  c_addr_o;
  logic [31:0] c_rdata_i;
  logic [1:0]  G_raddr_o;
  logic [3:0]  G_caddr_o;
  logic [31:0] G_rdata_i;
  logic [3:0]  A_raddr_o;
  logic [3:0]  A_caddr_o;
  logic [31:0] A_rdata_i;
  logic [3:0]  b_addr_o;
  logic [31:0] b_rdata_i;
  logic [31:0] m_tdata_o;
  logic [1:0]  m_tsection_o;
  logic        m_tvalid_o;
  logic        m_tready_i;
  logic        m_tlast_o;
`ifdef CZ_READOUT_HEADER_EN
  logic        m_thdr_o;
`endif
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  czonotope_readout dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .n_i          (n_i),
    .ng_i         (ng_i),
    .nc_i         (nc_i),
    .c_addr_o     (c_addr_o),
    .c_rdata_i    (c_rdata_i),
    .G_raddr_o    (G_raddr_o),
    .G_caddr_o    (G_caddr_o),
    .G_rdata_i    (G_rdata_i),
    .A_raddr_o    (A_raddr_o),
    .A_caddr_o    (A_caddr_o),
    .A_rdata_i    (A_rdata_i),
    .b_addr_o     (b_addr_o),
    .b_rdata_i    (b_rdata_i),
    .m_tdata_o    (m_tdata_o),
    .m_tsection_o (m_tsection_o),
    .m_tvalid_o   (m_tvalid_o),
    .m_tready_i   (m_tready_i),
    .m_tlast_o    (m_tlast_o),
`ifdef CZ_READOUT_HEADER_EN
    .m_thdr_o     (m_thdr_o),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result memories with one cycle of read latency
  logic [31:0] cmem [4];
  logic [31:0] gmem [4][16];
  logic [31:0] amem [16][16];
  logic [31:0] bmem [16];

  always @(posedge clk) begin
    c_rdata_i <= cmem[c_addr_o];
    G_rdata_i <= gmem[G_raddr_o][G_caddr_o];
    A_rdata_i <= amem[A_raddr_o][A_caddr_o];
    b_rdata_i <= bmem[b_addr_o];
  end

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic        l;
    logic        h;
  } word_t;

  word_t exp_q [$];
  int    n_checks = 0;
  int    n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_mems();
    for (int i = 0; i < 4; i++) cmem[i] = $urandom;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) gmem[i][j] = $urandom;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) amem[i][j] = $urandom;
    for (int i = 0; i < 16; i++) bmem[i] = $urandom;
  endtask

  // Expected stream: c, G row-major, A row-major, b; last flag on the final word
  task automatic build(input int n, input int ng, input int nc);
    word_t w;
    exp_q.delete();
`ifdef CZ_READOUT_HEADER_EN
    w = '{d: (nc << 8) | (ng << 4) | n, s: 2'd0, l: 1'b0, h: 1'b1};
    exp_q.push_back(w);
`endif
    for (int i = 0; i < n; i++) begin
      w = '{d: cmem[i], s: 2'd0, l: 1'b0, h: 1'b0};
      exp_q.push_back(w);
    end
    for (int r = 0; r < n; r++)
      for (int k = 0; k < ng; k++) begin
        w = '{d: gmem[r][k], s: 2'd1, l: 1'b0, h: 1'b0};
        exp_q.push_back(w);
      end
    for (int r = 0; r < nc; r++)
      for (int k = 0; k < ng; k++) begin
        w = '{d: amem[r][k], s: 2'd2, l: 1'b0, h: 1'b0};
        exp_q.push_back(w);
      end
    for (int i = 0; i < nc; i++) begin
      w = '{d: bmem[i], s: 2'd3, l: 1'b0, h: 1'b0};
      exp_q.push_back(w);
    end
    if (exp_q.size() > 0) begin
      w = exp_q.pop_back();
      w.l = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 1;
    return 1'($urandom_range(0, 1));
  endfunction

  // One transfer. mode: 0 always ready, 1 toggling, 2 random.
  // restart_k / rst_k: cycle offset for a second start / a reset (-1 = none).
  task automatic run(input int n, input int ng, input int nc, input int mode,
                     input int restart_k, input int rst_k);
    int    t0, w_cnt, stalls, lim;
    logic  first_seen, done_seen, held_vld;
    word_t held, e;

    fill_mems();
    build(n, ng, nc);
    w_cnt = exp_q.size();
    lim   = 4 * w_cnt + 20;

    @(posedge clk); #1;
    n_i = 2'(n); ng_i = 4'(ng); nc_i = 4'(nc);
    start_i    = 1'b1;
    m_tready_i = ready_for(mode, 0);
    t0 = cyc;
    check("start_tvalid", 64'(m_tvalid_o), 64'd0);
    check("start_busy",   64'(busy_o),     64'd0);

    stalls = 0; first_seen = 1'b0; done_seen = 1'b0; held_vld = 1'b0;
    held = '0;
    for (int k = 1; k <= lim && !done_seen; k++) begin
      @(posedge clk); #1;
      start_i = (k == restart_k);
      if (k == restart_k) begin
        n_i = 2'd1; ng_i = 4'd1; nc_i = 4'd1;
      end
      rst_i      = (k == rst_k);
      m_tready_i = ready_for(mode, k);

      if (rst_k > 0 && k == rst_k + 1) begin
        check("rst_tvalid", 64'(m_tvalid_o), 64'd0);
        check("rst_busy",   64'(busy_o),     64'd0);
        for (int q = 0; q < 5; q++) begin
          @(posedge clk); #1;
          check("rst_quiet", {62'd0, m_tvalid_o, done_o}, 64'd0);
        end
        start_i = 1'b0;
        return;
      end

      if (k == 1) check("busy_after_start", 64'(busy_o), 64'd1);
      if (m_tvalid_o && !first_seen) begin
        first_seen = 1'b1;
        check("first_valid_cycle", 64'(cyc - t0), 64'd3);
      end
      if (held_vld) begin
        check("stall_valid", 64'(m_tvalid_o), 64'd1);
        check("stall_stable", 64'({m_tdata_o, m_tsection_o, m_tlast_o}),
              64'({held.d, held.s, held.l}));
      end
      held_vld = 1'b0;
      if (m_tvalid_o) begin
        if (m_tready_i) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("word_data",    64'(m_tdata_o),    64'(e.d));
            check("word_section", 64'(m_tsection_o), 64'(e.s));
            check("word_last",    64'(m_tlast_o),    64'(e.l));
`ifdef CZ_READOUT_HEADER_EN
            check("word_hdr",     64'(m_thdr_o),     64'(e.h));
`endif
          end
        end else begin
          stalls++;
          held     = '{d: m_tdata_o, s: m_tsection_o, l: m_tlast_o, h: 1'b0};
          held_vld = 1'b1;
        end
      end
      if (done_o) begin
        done_seen = 1'b1;
        check("done_cycle", 64'(cyc - t0),
              (w_cnt == 0) ? 64'd2 : 64'(3 + w_cnt + stalls));
        check("done_busy",  64'(busy_o), 64'd0);
        check("done_words_left", 64'(exp_q.size()), 64'd0);
      end
    end
    start_i = 1'b0;
    rst_i   = 1'b0;
    if (!done_seen) check("done_timeout", 64'd0, 64'd1);
    for (int q = 0; q < 3; q++) begin
      @(posedge clk); #1;
      check("post_done_quiet", {62'd0, m_tvalid_o, done_o}, 64'd0);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; n_i = '0; ng_i = '0; nc_i = '0;
    m_tready_i = 1'b0;
    fill_mems();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", 64'(m_tvalid_o), 64'd0);
    check("reset_busy",   64'(busy_o),     64'd0);
    check("reset_done",   64'(done_o),     64'd0);
    check("reset_tdata",  64'({m_tdata_o, m_tsection_o, m_tlast_o}), 64'd0);
    check("reset_addr",   64'({c_addr_o, G_raddr_o, G_caddr_o, A_raddr_o,
                               A_caddr_o, b_addr_o}), 64'd0);
    rst_i = 1'b0;

    run(2, 3, 1, 0, -1, -1);   // basic 12-word stream
    run(2, 3, 1, 1, -1, -1);   // toggling ready
    run(0, 4, 2, 0, -1, -1);   // A then b only
    run(3, 0, 0, 0, -1, -1);   // c only
    run(0, 0, 0, 0, -1, -1);   // empty
    run(2, 3, 1, 0,  5, -1);   // second start ignored
    run(2, 3, 1, 0, -1,  7);   // reset mid-transfer
    run(2, 3, 1, 0, -1, -1);   // full stream after reset
    run(1, 1, 1, 2, -1, -1);
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 12),
          2, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
